vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640: visible pixels per line.
REQ-002 Parameters H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48: horizontal porch and sync widths, in pixels.
REQ-003 Parameter V_DISPLAY, default 480: visible lines per frame.
REQ-004 Parameters V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33: vertical porch and sync widths, in lines.
REQ-005 Parameter CLK_DIV, default 4: number of sys_clk cycles per pixel; minimum 2.
REQ-006 Parameter SCREEN_WIDTH, default 10: bit width of x and y.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 sys_clk, input, 1 bit: system clock, 100 MHz.
REQ-009 sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-010 p_tick, output, 1 bit: pixel-rate enable, one sys_clk cycle wide.
REQ-011 hsync, output, 1 bit: horizontal sync, active low.
REQ-012 vsync, output, 1 bit: vertical sync, active low.
REQ-013 video_on, output, 1 bit: high while the current pixel is in the visible area.
REQ-014 x, output, SCREEN_WIDTH bits: current horizontal pixel count.
REQ-015 y, output, SCREEN_WIDTH bits: current vertical line count.
REQ-016 frame_start, output, 1 bit: one-cycle pulse marking pixel (0,0).

Function
REQ-017 H_TOTAL and V_TOTAL: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
REQ-018 Width check: elaboration fails if H_TOTAL > 2^SCREEN_WIDTH or V_TOTAL > 2^SCREEN_WIDTH.
REQ-019 Divider: a counter modulo CLK_DIV asserts p_tick for exactly one sys_clk cycle in every CLK_DIV cycles.
REQ-020 First p_tick: asserted on the CLK_DIV-th rising edge after reset release.
REQ-021 Horizontal count: x increments only on p_tick and wraps from H_TOTAL-1 to 0.
REQ-022 Vertical count: y increments only on a p_tick where x wraps, and itself wraps from V_TOTAL-1 to 0.
REQ-023 Registered outputs: hsync, vsync, video_on and frame_start are registered and decoded from the next-state counter values, so they are aligned with the x/y they describe in the same cycle.
REQ-024 hsync: low iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (default 656..751).
REQ-025 vsync: low iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (default 490..491).
REQ-026 video_on: high iff x < H_DISPLAY and y < V_DISPLAY.
REQ-027 frame_start: high for the single sys_clk cycle in which (x,y) becomes (0,0); coincident with p_tick.
REQ-028 Hold between ticks: all outputs other than p_tick hold their values between p_ticks.

Reset
REQ-029 Reset values: while sys_rst_n is low, x=H_TOTAL-1, y=V_TOTAL-1, hsync=1, vsync=1, video_on=0, frame_start=0, p_tick=0, divider=0.
REQ-030 Effect of reset: assertion takes effect asynchronously at any point, including mid-line or mid-frame; release is sampled on sys_clk.
REQ-031 After release: the first p_tick wraps the counters to (0,0) and asserts frame_start, so no visible pixel of the first frame is lost.

Configuration
REQ-032 Macro VGA_SYNC_FRAME_CNT_EN, when defined, adds output frame_cnt, 8 bits.
REQ-033 frame_cnt behaviour: resets to 0, increments on each frame_start after the first, and wraps 255->0.
REQ-034 Without VGA_SYNC_FRAME_CNT_EN, the frame_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-035 Package vga_timing_pkg holds:
- the default timing constants;
- H_TOTAL/V_TOTAL derivation;
- RGB colour constants shared with the pixel path.
REQ-036 Sub-module: the pixel-enable divider is a separate sub-module, vga_pix_tick (parameter CLK_DIV, outputs p_tick); the counters and decode stay in vga_sync_gen.

Verification
REQ-037 Reset release: release sys_rst_n -> p_tick=0 for 3 cycles; 4th edge gives p_tick=1, x=0, y=0, video_on=1, frame_start=1, hsync=1, vsync=1.
REQ-038 Horizontal sweep: advance within line 0 ->
- x=640: video_on=0;
- x=656: hsync=0;
- x=752: hsync=1;
- tick after x=799: x=0, y=1.
REQ-039 Vertical sweep:
- y=490: vsync=0, held through y=491;
- y=492: vsync=1;
- (799,524) -> next p_tick gives (0,0) with frame_start=1.
REQ-040 Frame period: exactly 1,680,000 sys_clk cycles between consecutive frame_start pulses; exactly 420,000 p_ticks per frame.
REQ-041 Mid-frame reset: assert reset at x=300, y=200 -> outputs immediately take REQ-029 values; after release, sequence matches REQ-037.
REQ-042 With VGA_SYNC_FRAME_CNT_EN: frame_cnt=0 in frame 0 and 1 after the second frame_start; preload a count of 255 and run one more frame -> wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, frame-total derivation and RGB colour constants.
package vga_timing_pkg;

  localparam int unsigned H_DISPLAY_DEF    = 640;
  localparam int unsigned H_FRONT_DEF      = 16;
  localparam int unsigned H_SYNC_DEF       = 96;
  localparam int unsigned H_BACK_DEF       = 48;
  localparam int unsigned V_DISPLAY_DEF    = 480;
  localparam int unsigned V_FRONT_DEF      = 10;
  localparam int unsigned V_SYNC_DEF       = 2;
  localparam int unsigned V_BACK_DEF       = 33;
  localparam int unsigned CLK_DIV_DEF      = 4;
  localparam int unsigned SCREEN_WIDTH_DEF = 10;
  localparam int unsigned FRAME_CNT_W      = 8;

  // Total period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned timing_total(input int unsigned disp,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
    return disp + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL_DEF =
    timing_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL_DEF =
    timing_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  localparam int unsigned RGB_CH_W = 4;

  typedef struct packed {
    logic [RGB_CH_W-1:0] r;
    logic [RGB_CH_W-1:0] g;
    logic [RGB_CH_W-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_WHITE = '{r: 4'hf, g: 4'hf, b: 4'hf};
  localparam rgb_t RGB_RED   = '{r: 4'hf, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_GREEN = '{r: 4'h0, g: 4'hf, b: 4'h0};
  localparam rgb_t RGB_BLUE  = '{r: 4'h0, g: 4'h0, b: 4'hf};

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate enable: one-cycle p_tick every CLK_DIV sys_clk cycles.
// tick_c is the early (pre-edge) form used to advance the counters in lockstep.
module vga_pix_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick_c,
  output logic p_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (CLK_DIV < 2) begin : g_div_chk
      $error("vga_pix_tick: CLK_DIV must be at least 2");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;

  assign tick_c = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Tick registers on the edge where the divider wraps, i.e. the CLK_DIV-th edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      p_tick  <= tick_c;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters and registered sync/blank/frame decode.
// Optional frame_cnt output enabled by `define VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY    = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT      = H_FRONT_DEF,
  parameter int unsigned H_SYNC       = H_SYNC_DEF,
  parameter int unsigned H_BACK       = H_BACK_DEF,
  parameter int unsigned V_DISPLAY    = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT      = V_FRONT_DEF,
  parameter int unsigned V_SYNC       = V_SYNC_DEF,
  parameter int unsigned V_BACK       = V_BACK_DEF,
  parameter int unsigned CLK_DIV      = CLK_DIV_DEF,
  parameter int unsigned SCREEN_WIDTH = SCREEN_WIDTH_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  output logic                    p_tick,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    video_on,
  output logic [SCREEN_WIDTH-1:0] x,
  output logic [SCREEN_WIDTH-1:0] y,
  output logic                    frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0]  frame_cnt
`endif
);

  localparam int unsigned W          = SCREEN_WIDTH;
  localparam int unsigned H_TOTAL    = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL    = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned H_SYNC_BEG = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

  generate
    if (H_TOTAL > (64'd1 << SCREEN_WIDTH)) begin : g_h_width_chk
      $error("vga_sync_gen: H_TOTAL does not fit in SCREEN_WIDTH bits");
    end
    if (V_TOTAL > (64'd1 << SCREEN_WIDTH)) begin : g_v_width_chk
      $error("vga_sync_gen: V_TOTAL does not fit in SCREEN_WIDTH bits");
    end
  endgenerate

  logic tick_c;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick_c    (tick_c),
    .p_tick    (p_tick)
  );

  logic [W-1:0] x_nxt;
  logic [W-1:0] y_nxt;
  logic         hsync_nxt;
  logic         vsync_nxt;
  logic         video_on_nxt;
  logic         frame_start_nxt;

  // Next raster position plus decode of that position, so registered
  // sync/blank outputs line up with the registered x/y they describe.
  always_comb begin
    x_nxt           = x;
    y_nxt           = y;
    hsync_nxt       = 1'b1;
    vsync_nxt       = 1'b1;
    video_on_nxt    = 1'b0;
    frame_start_nxt = 1'b0;

    if (tick_c) begin
      if (32'(x) == H_TOTAL - 1) begin
        x_nxt = '0;
        if (32'(y) == V_TOTAL - 1) begin
          y_nxt = '0;
        end else begin
          y_nxt = y + W'(1);
        end
      end else begin
        x_nxt = x + W'(1);
      end
    end

    // Comparisons done in 32 bits so a sync end equal to 2^W cannot alias to 0.
    hsync_nxt       = !((32'(x_nxt) >= H_SYNC_BEG) && (32'(x_nxt) < H_SYNC_END));
    vsync_nxt       = !((32'(y_nxt) >= V_SYNC_BEG) && (32'(y_nxt) < V_SYNC_END));
    video_on_nxt    = (32'(x_nxt) < H_DISPLAY) && (32'(y_nxt) < V_DISPLAY);
    frame_start_nxt = tick_c && (x_nxt == '0) && (y_nxt == '0);
  end

  // Reset parks the raster on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x           <= W'(H_TOTAL - 1);
      y           <= W'(V_TOTAL - 1);
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      video_on    <= video_on_nxt;
      frame_start <= frame_start_nxt;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic first_seen;

  // The frame starting at reset release is frame 0; later frame starts count up.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      first_seen <= 1'b0;
      frame_cnt  <= '0;
    end else if (frame_start_nxt) begin
      first_seen <= 1'b1;
      if (first_seen) begin
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end
`endif

endmodule
